cmd_uart_resp: RTL and testbench

CMD_UART_RESP -- requirements
Module: cmd_uart_resp

---
 rtl/cmd_uart_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_cmd_uart_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_uart_resp.sv
`default_nettype none
// ============================================================================
// Module      : cmd_uart_resp
// Description : UART command receiver (two bytes, high first, assembled into
//               a 16-bit command) plus an independent one-byte UART response
//               transmitter. Optional inter-byte timeout: CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_uart_resp #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frm_err
);

    localparam logic [11:0] c_baud_full = 12'(BAUD_DIV - 1);
    localparam logic [11:0] c_baud_half = 12'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [0:0] c_wait_hi = 1'b0;
    localparam logic [0:0] c_wait_lo = 1'b1;

    localparam logic [0:0] c_tx_idle = 1'b0;
    localparam logic [0:0] c_tx_busy = 1'b1;

    if (BAUD_DIV < 8 || BAUD_DIV > 4095 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("cmd_uart_resp: BAUD_DIV or TIMEOUT_CYC out of range");
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]  r_rx_state, w_rx_state_nxt;
    logic [11:0] r_rx_baud;
    logic [2:0]  r_rx_bitcnt;
    logic [7:0]  r_rx_shift;
    logic        r_byte_vld;
    logic        r_frm_err;
    logic        w_rx_tick, w_start_det;

    assign w_rx_tick   = (r_rx_baud == 12'd0);
    assign w_start_det = r_rx_prev & ~r_rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_rx_idle:  if (w_start_det) w_rx_state_nxt = c_rx_start;
            c_rx_start: if (w_rx_tick) w_rx_state_nxt = r_rx_sync ? c_rx_idle : c_rx_data;
            c_rx_data:  if (w_rx_tick && r_rx_bitcnt == 3'd7) w_rx_state_nxt = c_rx_stop;
            c_rx_stop:  if (w_rx_tick) w_rx_state_nxt = c_rx_idle;
            default:    w_rx_state_nxt = c_rx_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= c_rx_idle;
            r_rx_baud   <= 12'd0;
            r_rx_bitcnt <= 3'd0;
            r_rx_shift  <= 8'd0;
            r_byte_vld  <= 1'b0;
            r_frm_err   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
            if (r_rx_state == c_rx_idle) begin
                if (w_start_det) r_rx_baud <= c_baud_half;
            end else if (w_rx_tick) begin
                r_rx_baud <= c_baud_full;
                if (r_rx_state == c_rx_start) r_rx_bitcnt <= 3'd0;
                if (r_rx_state == c_rx_data) begin
                    r_rx_shift  <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
                end
                if (r_rx_state == c_rx_stop) begin
                    r_byte_vld <= r_rx_sync;
                    r_frm_err  <= ~r_rx_sync;
                end
            end else begin
                r_rx_baud <= r_rx_baud - 12'd1;
            end
        end
    end

    assign frm_err = r_frm_err;

    // ------------------------------------------------------------------
    // Command assembler
    // ------------------------------------------------------------------
    logic [0:0]  r_asm_state, w_asm_state_nxt;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        w_timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);
    logic [c_to_w-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_asm_state == c_wait_hi || r_byte_vld) r_to_cnt <= '0;
        else if (!w_timeout) r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_asm_state == c_wait_lo) &&
                       (r_to_cnt == c_to_w'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A byte arriving in the same cycle as the timeout takes priority.
    always_comb begin
        w_asm_state_nxt = r_asm_state;
        if (r_byte_vld)
            w_asm_state_nxt = (r_asm_state == c_wait_hi) ? c_wait_lo : c_wait_hi;
        else if (w_timeout)
            w_asm_state_nxt = c_wait_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_state <= c_wait_hi;
            r_cmd       <= 16'h0000;
            r_cmd_rdy   <= 1'b0;
        end else begin
            r_asm_state <= w_asm_state_nxt;
            if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
            if (r_byte_vld) begin
                if (r_asm_state == c_wait_hi) begin
                    r_cmd[15:8] <= r_rx_shift;
                    r_cmd_rdy   <= 1'b0;
                end else begin
                    r_cmd[7:0]  <= r_rx_shift;
                    r_cmd_rdy   <= 1'b1;
                end
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // ------------------------------------------------------------------
    // Transmitter: start bit driven directly, then {stop, data} shifted LSB first
    // ------------------------------------------------------------------
    logic [0:0]  r_tx_state, w_tx_state_nxt;
    logic [11:0] r_tx_baud;
    logic [3:0]  r_tx_bitcnt;
    logic [8:0]  r_tx_shift;
    logic        r_tx, r_tx_done;
    logic        w_tx_tick, w_tx_last;

    assign w_tx_tick = (r_tx_baud == 12'd0);
    assign w_tx_last = w_tx_tick && (r_tx_bitcnt == 4'd9);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_tx_idle: if (trmt) w_tx_state_nxt = c_tx_busy;
            c_tx_busy: if (w_tx_last) w_tx_state_nxt = c_tx_idle;
            default:   w_tx_state_nxt = c_tx_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= c_tx_idle;
            r_tx_baud   <= 12'd0;
            r_tx_bitcnt <= 4'd0;
            r_tx_shift  <= 9'h1FF;
            r_tx        <= 1'b1;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (r_tx_state == c_tx_idle) begin
                if (trmt) begin
                    r_tx_shift  <= {1'b1, resp};
                    r_tx        <= 1'b0;
                    r_tx_baud   <= c_baud_full;
                    r_tx_bitcnt <= 4'd0;
                    r_tx_done   <= 1'b0;
                end
            end else if (w_tx_last) begin
                r_tx_done <= 1'b1;
            end else if (w_tx_tick) begin
                r_tx        <= r_tx_shift[0];
                r_tx_shift  <= {1'b1, r_tx_shift[8:1]};
                r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
                r_tx_baud   <= c_baud_full;
            end else begin
                r_tx_baud <= r_tx_baud - 12'd1;
            end
        end
    end

    assign TX      = r_tx;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_cmd_uart_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_uart_resp
// Description : Directed self-checking bench for cmd_uart_resp (BAUD_DIV=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_uart_resp;

    localparam int BAUD = 16;
    localparam int TO   = 2000;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done, frm_err;
    logic [15:0] cmd;
    logic [7:0]  resp;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int frm_cnt  = 0;
    int rdy_rise = -1;
    logic rdy_q  = 1'b0;

    cmd_uart_resp #(.BAUD_DIV(BAUD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt),
        .tx_done(tx_done), .frm_err(frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frm_err) frm_cnt++;
        if (cmd_rdy && !rdy_q) rdy_rise = cyc;
        rdy_q = cmd_rdy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 200000", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cyc(BAUD);
        end
        RX = stop;
        wait_cyc(BAUD);
        RX = 1'b1;
    endtask

    task automatic pulse_trmt(input logic [7:0] b);
        resp = b;
        trmt = 1'b1;
        wait_cyc(1);
        trmt = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(3);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
        checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        rst = 1'b0;
        wait_cyc(3);
    endtask

    task automatic test_cmd_rx;
        int c0;
        send_byte(8'hA5, 1'b1);
        wait_cyc(4);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rx_hi_only_rdy: got %b want 0", cmd_rdy); end
        checks++; if (cmd[15:8] !== 8'hA5) begin errors++; $display("FAIL rx_hi_byte: got %h want a5", cmd[15:8]); end
        c0 = cyc;
        rdy_rise = -1;
        send_byte(8'h3C, 1'b1);
        checks++; if (cmd !== 16'hA53C) begin errors++; $display("FAIL rx_cmd_a53c: got %h want a53c", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rx_cmd_rdy: got %b want 1", cmd_rdy); end
        checks++;
        if (rdy_rise < c0 + 153 || rdy_rise > c0 + 158) begin
            errors++; $display("FAIL rx_rdy_latency: rose at offset %0d want 153..158", rdy_rise - c0);
        end
        wait_cyc(20);
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy_hold: got %b want 1", cmd_rdy); end
        clr_cmd_rdy = 1'b1;
        wait_cyc(1);
        clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rx_rdy_clear: got %b want 0", cmd_rdy); end
        checks++; if (cmd !== 16'hA53C) begin errors++; $display("FAIL rx_cmd_after_clr: got %h want a53c", cmd); end
    endtask

    task automatic test_tx;
        logic [9:0] exp;
        int w;
        exp = {1'b1, 8'hA5, 1'b0};
        resp = 8'hA5;
        trmt = 1'b1;
        wait_cyc(1);
        trmt = 1'b0;
        resp = 8'hFF;
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL tx_start_edge: got %b want 0", TX); end
        for (int k = 0; k < 10; k++) begin
            w = (k == 0) ? 8 : ((k == 3) ? 15 : 16);
            wait_cyc(w);
            checks++;
            if (TX !== exp[k]) begin errors++; $display("FAIL tx_bit%0d: got %b want %b", k, TX, exp[k]); end
            if (k == 2) pulse_trmt(8'h0F);
        end
        wait_cyc(7);
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL tx_done_early: got %b want 0", tx_done); end
        wait_cyc(1);
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL tx_done_160: got %b want 1", tx_done); end
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_idle_after: got %b want 1", TX); end
        pulse_trmt(8'h00);
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL tx_done_clear: got %b want 0", tx_done); end
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL tx_second_start: got %b want 0", TX); end
        wait_cyc(170);
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL tx_done_second: got %b want 1", tx_done); end
    endtask

    task automatic test_frame_err;
        int f0;
        f0 = frm_cnt;
        send_byte(8'h12, 1'b0);
        wait_cyc(4);
        checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL frm_err_pulse: got %0d cycles want 1", frm_cnt - f0); end
        send_byte(8'h12, 1'b1);
        wait_cyc(4);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL frm_state_hi: cmd_rdy got %b want 0", cmd_rdy); end
        send_byte(8'h34, 1'b1);
        wait_cyc(2);
        checks++; if (cmd !== 16'h1234) begin errors++; $display("FAIL frm_cmd_1234: got %h want 1234", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL frm_cmd_rdy: got %b want 1", cmd_rdy); end
        checks++; if (frm_cnt - f0 !== 1) begin errors++; $display("FAIL frm_no_extra: got %0d want 1", frm_cnt - f0); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h11, 1'b1);
        wait_cyc(4);
        pulse_trmt(8'h00);
        RX = 1'b0;
        wait_cyc(BAUD);
        for (int i = 0; i < 3; i++) begin
            RX = (i == 1);
            wait_cyc(BAUD);
        end
        rst = 1'b1;
        RX  = 1'b1;
        wait_cyc(2);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b want 1", TX); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL mid_rst_cmd: got %h want 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_rdy: got %b want 0", cmd_rdy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", tx_done); end
        rst = 1'b0;
        wait_cyc(4);
        send_byte(8'hBE, 1'b1);
        wait_cyc(3);
        send_byte(8'hEF, 1'b1);
        wait_cyc(2);
        checks++; if (cmd !== 16'hBEEF) begin errors++; $display("FAIL mid_cmd_beef: got %h want beef", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_cmd_rdy: got %b want 1", cmd_rdy); end
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_tx_idle: got %b want 1", TX); end
    endtask

    task automatic test_timeout;
        send_byte(8'h55, 1'b1);
        wait_cyc(TO);
        send_byte(8'h66, 1'b1);
        wait_cyc(2);
`ifdef CMD_TIMEOUT_EN
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL to_66_rdy: got %b want 0", cmd_rdy); end
        checks++; if (cmd[15:8] !== 8'h66) begin errors++; $display("FAIL to_66_hi: got %h want 66", cmd[15:8]); end
        send_byte(8'h77, 1'b1);
        wait_cyc(2);
        checks++; if (cmd !== 16'h6677) begin errors++; $display("FAIL to_cmd_6677: got %h want 6677", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL to_rdy: got %b want 1", cmd_rdy); end
`else
        checks++; if (cmd !== 16'h5566) begin errors++; $display("FAIL nto_cmd_5566: got %h want 5566", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL nto_rdy: got %b want 1", cmd_rdy); end
        send_byte(8'h77, 1'b1);
        wait_cyc(2);
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL nto_77_rdy: got %b want 0", cmd_rdy); end
        send_byte(8'h88, 1'b1);
        wait_cyc(2);
        checks++; if (cmd !== 16'h7788) begin errors++; $display("FAIL nto_cmd_7788: got %h want 7788", cmd); end
`endif
    endtask

    task automatic test_back_to_back;
        int c0;
        pulse_trmt(8'h3C);
        send_byte(8'hC3, 1'b1);
        c0 = cyc;
        rdy_rise = -1;
        clr_cmd_rdy = 1'b1;
        send_byte(8'h9A, 1'b1);
        wait_cyc(1);
        clr_cmd_rdy = 1'b0;
        wait_cyc(1);
        checks++; if (cmd !== 16'hC39A) begin errors++; $display("FAIL b2b_cmd_c39a: got %h want c39a", cmd); end
        checks++; if (rdy_rise < c0) begin errors++; $display("FAIL b2b_set_wins: rise cycle %0d want >= %0d", rdy_rise, c0); end
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_clr_after: got %b want 0", cmd_rdy); end
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_tx_done: got %b want 1", tx_done); end
    endtask

    task automatic test_glitch;
        int f0;
        logic [15:0] cmd0;
        logic rdy0;
        f0   = frm_cnt;
        cmd0 = cmd;
        rdy0 = cmd_rdy;
        RX = 1'b0;
        wait_cyc(4);
        RX = 1'b1;
        wait_cyc(3 * BAUD);
        checks++; if (frm_cnt !== f0) begin errors++; $display("FAIL glitch_frm: got %0d want %0d", frm_cnt, f0); end
        checks++; if (cmd !== cmd0) begin errors++; $display("FAIL glitch_cmd: got %h want %h", cmd, cmd0); end
        checks++; if (cmd_rdy !== rdy0) begin errors++; $display("FAIL glitch_rdy: got %b want %b", cmd_rdy, rdy0); end
        send_byte(8'hD1, 1'b1);
        send_byte(8'hE2, 1'b1);
        wait_cyc(2);
        checks++; if (cmd !== 16'hD1E2) begin errors++; $display("FAIL glitch_then_cmd: got %h want d1e2", cmd); end
    endtask

    initial begin
        rst         = 1'b1;
        RX          = 1'b1;
        trmt        = 1'b0;
        resp        = 8'h00;
        clr_cmd_rdy = 1'b0;
        wait_cyc(1);
        test_reset;
        test_cmd_rx;
        test_tx;
        test_frame_err;
        test_reset_mid;
        test_timeout;
        test_back_to_back;
        test_glitch;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
